bcd_seg_scan: RTL and testbench

- Downstream consumer of the bin_to_bcd stage: takes its ones/tens/hundreds BCD digits and drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Samples the three digits once per scan frame, so a value change mid-scan never tears the display.
- Cycles digit slots at a programmable refresh rate, with anti-ghost blanking at the end of each slot.

---
 rtl/bcd_seg_scan.sv | 110 +++++++++++
 tb/tb_bcd_seg_scan.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for BCD ones/tens/hundreds.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens slots.
module bcd_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_START = CW'(REFRESH_DIV - BLANK_CYCLES);

  logic [CW-1:0] div_cnt, div_nxt;
  logic [1:0]    slot, slot_nxt;
  logic [3:0]    s_ones, s_tens, s_hund;
  logic [3:0]    s_ones_nxt, s_tens_nxt, s_hund_nxt;
  logic [3:0]    digit;
  logic          wrap, blank;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          frame_done_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Inputs have no handshake: they are sampled only on the last clock of slot 3,
  // so the whole next frame shows one coherent value.
  always_comb begin
    wrap       = (div_cnt == DIV_LAST);
    div_nxt    = wrap ? '0 : div_cnt + 1'b1;
    slot_nxt   = slot + {1'b0, wrap};
    s_ones_nxt = s_ones;
    s_tens_nxt = s_tens;
    s_hund_nxt = s_hund;
    if (wrap && slot == 2'd3) begin
      s_ones_nxt = ones;
      s_tens_nxt = tens;
      s_hund_nxt = hundreds;
    end
  end

  // Output stage looks at next-state values so the registered an/seg line up
  // with the slot counter on the same clock.
  always_comb begin
    digit = s_ones_nxt;
    case (slot_nxt)
      2'd1:    digit = s_tens_nxt;
      2'd2:    digit = s_hund_nxt;
      default: digit = s_ones_nxt;
    endcase
    blank = (div_nxt >= BLANK_START) || (slot_nxt == 2'd3);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot_nxt == 2'd2 && s_hund_nxt == 4'd0)
      blank = 1'b1;
    if (slot_nxt == 2'd1 && s_hund_nxt == 4'd0 && s_tens_nxt == 4'd0)
      blank = 1'b1;
`endif
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    if (!blank) begin
      an_nxt  = ~(4'b0001 << slot_nxt);
      seg_nxt = decode(digit);
    end
    frame_done_nxt = (div_nxt == DIV_LAST) && (slot_nxt == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      slot       <= 2'd0;
      s_ones     <= 4'd0;
      s_tens     <= 4'd0;
      s_hund     <= 4'd0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      slot       <= slot_nxt;
      s_ones     <= s_ones_nxt;
      s_tens     <= s_tens_nxt;
      s_hund     <= s_hund_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: cycle-position reference model plus literal pins.
module tb_bcd_seg_scan;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ones, tens, hundreds;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int n = 0;            // rising edges since reset release
  logic [3:0] m_o = 4'd0, m_t = 4'd0, m_h = 4'd0;
  int fd_count = 0;
  int last_fd = 0;
  bit last_valid = 1'b0;

  bcd_seg_scan #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .ones(ones), .tens(tens), .hundreds(hundreds),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", name, act, exp, n, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
            7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    return tbl[d];
  endfunction

  // Reference: position in frame is n mod FRAME; slot and offset follow by division.
  always @(posedge clk) begin
    int p, sl, d;
    logic [3:0] dig;
    bit blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    if (rst_n) begin
      n++;
      if (n % FRAME == 0) begin
        m_o = ones; m_t = tens; m_h = hundreds;
      end
      #1;
      p  = n % FRAME;
      sl = p / DIV;
      d  = p % DIV;
      dig = (sl == 0) ? m_o : (sl == 1) ? m_t : m_h;
      blank = (d >= DIV - BLANK) || (sl == 3);
`ifdef LEADING_ZERO_BLANK_EN
      if (sl == 2 && m_h == 0) blank = 1'b1;
      if (sl == 1 && m_h == 0 && m_t == 0) blank = 1'b1;
`endif
      e_an  = blank ? 4'b1111 : ~(4'b0001 << sl);
      e_seg = blank ? 7'b1111111 : seg_of(dig);
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_frame_done", frame_done, (p == FRAME - 1));
      chk("an_onehot", ($countones(~an) <= 1), 1);
      chk("an3_high", an[3], 1'b1);
      if (frame_done) begin
        if (last_valid) chk("fd_spacing", n - last_fd, FRAME);
        last_fd = n;
        last_valid = 1'b1;
        fd_count++;
      end
    end else begin
      #1;
      chk("rst_an", an, 4'b1111);
      chk("rst_seg", seg, 7'b1111111);
      chk("rst_fd", frame_done, 1'b0);
    end
  end

  always @(negedge rst_n) begin
    n = 0;
    m_o = 4'd0; m_t = 4'd0; m_h = 4'd0;
    last_valid = 1'b0;
  end

  task automatic wait_n(input int target);
    int guard = 0;
    while (n < target && guard < 2000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (n != target) chk("wait_n_reached", n, target);
  endtask

  task automatic set_val(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    hundreds = h; tens = t; ones = o;
  endtask

  initial begin
    set_val(4'd2, 4'd4, 4'd8);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First frame shows zeros, 248 captured at the end of it
    wait_n(1);
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'b1000000);
    wait_n(15);
    chk("capture_fd", frame_done, 1'b1);
    chk("capture_an", an, 4'b1111);
    wait_n(16);
    chk("s0_an", an, 4'b1110);
    chk("s0_seg", seg, 7'b0000000);
    wait_n(19);
    chk("s0_blank_an", an, 4'b1111);
    wait_n(20);
    chk("s1_an", an, 4'b1101);
    chk("s1_seg", seg, 7'b0011001);
    wait_n(24);
    chk("s2_an", an, 4'b1011);
    chk("s2_seg", seg, 7'b0100100);

    // Change during slot 1: display holds until the frame boundary
    wait_n(36);
    set_val(4'd1, 4'd3, 4'd9);
    wait_n(40);
    chk("hold_s2_seg", seg, 7'b0100100);
    wait_n(48);
    chk("new_s0_seg", seg, 7'b0010000);
    wait_n(52);
    chk("new_s1_seg", seg, 7'b0110000);
    wait_n(56);
    chk("new_s2_seg", seg, 7'b1111001);

    // Value 10: leading zero in hundreds
    set_val(4'd0, 4'd1, 4'd0);
    wait_n(68);
    chk("v10_s1_an", an, 4'b1101);
    chk("v10_s1_seg", seg, 7'b1111001);
    wait_n(72);
`ifdef LEADING_ZERO_BLANK_EN
    chk("v10_s2_an", an, 4'b1111);
    chk("v10_s2_seg", seg, 7'b1111111);
`else
    chk("v10_s2_an", an, 4'b1011);
    chk("v10_s2_seg", seg, 7'b1000000);
`endif

    // Invalid BCD digit shows a dash
    set_val(4'd0, 4'd1, 4'hA);
    wait_n(80);
    chk("inv_s0_seg", seg, 7'b0111111);

    // Asynchronous reset in the middle of slot 2
    wait_n(89);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'b1111);
    chk("async_seg", seg, 7'b1111111);
    chk("async_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_n(1);
    chk("restart_an", an, 4'b1110);
    chk("restart_seg", seg, 7'b1000000);

    // 40 frames with randomly changing inputs
    wait_n(16);
    fd_count = 0;
    while (n < 16 + 40 * FRAME) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        set_val(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    chk("fd_count_40", fd_count, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
